// File: rtl/cake_game.sv
// ---------------------------------------------------------------------------
// cake_game: BitBakery cake-assembly minigame.
// Each round shows one ingredient from a fixed recipe. The player must press
// exactly that button before the round timer expires. The game tracks the
// score and raises pronto once all rounds have been played.
//
// Ports:
//   clock        system clock, rising-edge active
//   reset        asynchronous active-low reset
//   jogar        start request, sampled in INICIAL and FIM
//   dificuldade  0 = easy, 1 = hard; latched in PREPARA
//   botoes[6:0]  ingredient buttons, active-high
//   estado[3:0]  current FSM state code
//   jogadas[6:0] one-hot target (MOSTRA/ESPERA) or captured press (ACERTO/ERRO)
//   pontuacao[2:0] number of correct rounds, saturating at 7
//   pronto       high while in FIM
// ---------------------------------------------------------------------------
module cake_game #(
  parameter int unsigned TEMPO_FACIL     = 3000,
  parameter int unsigned TEMPO_DIFICIL   = 1500,
  parameter int unsigned RODADAS_FACIL   = 4,
  parameter int unsigned RODADAS_DIFICIL = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       dificuldade,
  input  logic [6:0] botoes,
  output logic [3:0] estado,
  output logic [6:0] jogadas,
  output logic [2:0] pontuacao,
  output logic       pronto
);

  localparam int unsigned NB        = 7;
  localparam int unsigned TEMPO_MAX = (TEMPO_FACIL > TEMPO_DIFICIL) ? TEMPO_FACIL : TEMPO_DIFICIL;
  localparam int unsigned TW        = (TEMPO_MAX > 2) ? $clog2(TEMPO_MAX) : 1;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    MOSTRA  = 4'd2,
    ESPERA  = 4'd3,
    ACERTO  = 4'd4,
    ERRO    = 4'd5,
    PROXIMA = 4'd6,
    FIM     = 4'd7
  } estado_t;

  estado_t         r_estado;
  logic [TW-1:0]   r_tempo;
  logic [2:0]      r_rodada;
  logic [2:0]      r_pontos;
  logic            r_dif;
  logic            r_pronto;
  logic [NB-1:0]   r_botoes_ant;
  logic [NB-1:0]   r_alvo;
  logic [NB-1:0]   r_jogadas;

  logic            w_evento;
  logic [TW-1:0]   w_limite;
  logic [2:0]      w_ultima;
  logic [2:0]      w_rodada_prox;

  // Recipe ROM: round index -> one-hot ingredient.
  function automatic logic [6:0] f_alvo(input logic [2:0] idx);
    case (idx)
      3'd0:    f_alvo = 7'b0000001;
      3'd1:    f_alvo = 7'b0001000;
      3'd2:    f_alvo = 7'b0100000;
      3'd3:    f_alvo = 7'b0000010;
      3'd4:    f_alvo = 7'b1000000;
      3'd5:    f_alvo = 7'b0000100;
      3'd6:    f_alvo = 7'b0010000;
      default: f_alvo = 7'b0000001;
    endcase
  endfunction

  // A press only counts on a rising edge of "any button down".
  assign w_evento      = (r_botoes_ant == '0) && (botoes != '0);
  assign w_limite      = r_dif ? TW'(TEMPO_DIFICIL - 1) : TW'(TEMPO_FACIL - 1);
  assign w_ultima      = r_dif ? 3'(RODADAS_DIFICIL - 1) : 3'(RODADAS_FACIL - 1);
  assign w_rodada_prox = r_rodada + 3'd1;

  // Game FSM; every output is set on the edge that enters its state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado     <= INICIAL;
      r_tempo      <= '0;
      r_rodada     <= '0;
      r_pontos     <= '0;
      r_dif        <= 1'b0;
      r_pronto     <= 1'b0;
      r_botoes_ant <= '0;
      r_alvo       <= '0;
      r_jogadas    <= '0;
    end else begin
      r_botoes_ant <= botoes;
      case (r_estado)
        INICIAL: begin
          if (jogar) begin
            r_estado <= PREPARA;
            r_pontos <= '0;
          end
        end
        PREPARA: begin
          r_pontos  <= '0;
          r_rodada  <= '0;
          r_tempo   <= '0;
          r_dif     <= dificuldade;
          r_jogadas <= f_alvo(3'd0);
          r_estado  <= MOSTRA;
        end
        MOSTRA: begin
          r_alvo    <= f_alvo(r_rodada);
          r_jogadas <= f_alvo(r_rodada);
          r_tempo   <= '0;
          r_estado  <= ESPERA;
        end
        ESPERA: begin
          r_tempo <= r_tempo + TW'(1);
          // A press in the final timer cycle still wins over the timeout.
          if (w_evento) begin
            r_jogadas <= botoes;
            r_estado  <= (botoes == r_alvo) ? ACERTO : ERRO;
          end else if (r_tempo == w_limite) begin
            r_jogadas <= '0;
            r_estado  <= ERRO;
          end
        end
        ACERTO: begin
          if (r_pontos != 3'd7) begin
            r_pontos <= r_pontos + 3'd1;
          end
          r_jogadas <= '0;
          r_estado  <= PROXIMA;
        end
        ERRO: begin
          r_jogadas <= '0;
          r_estado  <= PROXIMA;
        end
        PROXIMA: begin
          if (r_rodada == w_ultima) begin
            r_pronto <= 1'b1;
            r_estado <= FIM;
          end else begin
            r_rodada  <= w_rodada_prox;
            r_jogadas <= f_alvo(w_rodada_prox);
            r_estado  <= MOSTRA;
          end
        end
        FIM: begin
          if (jogar) begin
            r_pronto <= 1'b0;
            r_pontos <= '0;
            r_estado <= PREPARA;
          end
        end
        default: begin
          r_jogadas <= '0;
          r_pronto  <= 1'b0;
          r_estado  <= INICIAL;
        end
      endcase
    end
  end

  assign estado    = r_estado;
  assign jogadas   = r_jogadas;
  assign pontuacao = r_pontos;
  assign pronto    = r_pronto;

endmodule

// File: tb/tb_cake_game.sv
// ---------------------------------------------------------------------------
// tb_cake_game: directed self-checking bench for cake_game.
// Timeouts are shortened (easy = 10, hard = 20 cycles) to keep runs short.
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cake_game;

  localparam int unsigned T_FACIL   = 10;
  localparam int unsigned T_DIFICIL = 20;

  logic       clock;
  logic       reset;
  logic       jogar;
  logic       dificuldade;
  logic [6:0] botoes;
  logic [3:0] estado;
  logic [6:0] jogadas;
  logic [2:0] pontuacao;
  logic       pronto;

  int checks   = 0;
  int failures = 0;

  cake_game #(
    .TEMPO_FACIL    (T_FACIL),
    .TEMPO_DIFICIL  (T_DIFICIL),
    .RODADAS_FACIL  (4),
    .RODADAS_DIFICIL(7)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .jogar      (jogar),
    .dificuldade(dificuldade),
    .botoes     (botoes),
    .estado     (estado),
    .jogadas    (jogadas),
    .pontuacao  (pontuacao),
    .pronto     (pronto)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b0; jogar = 1'b0; dificuldade = 1'b0; botoes = '0;
    step(); step();
    reset = 1'b1;
    step();
    checks++;
    if (estado !== 4'd0 || jogadas !== 7'd0 || pontuacao !== 3'd0 || pronto !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: estado=%0d jogadas=%b pontuacao=%0d pronto=%b, want 0/0/0/0",
               estado, jogadas, pontuacao, pronto);
    end
  endtask

  // Start a game from INICIAL or FIM; leaves the DUT in MOSTRA of round 0.
  task automatic start_game(input logic dif, input string nm);
    jogar = 1'b1; dificuldade = dif;
    step();
    jogar = 1'b0;
    checks++;
    if (estado !== 4'd1 || pontuacao !== 3'd0 || pronto !== 1'b0) begin
      failures++;
      $display("FAIL %s_prepara: estado=%0d pontuacao=%0d pronto=%b, want 1/0/0",
               nm, estado, pontuacao, pronto);
    end
    step();
  endtask

  // One round from MOSTRA through PROXIMA; press == 0 means let it time out.
  task automatic play_round(input logic [6:0] tgt, input logic [6:0] press,
                            input int unsigned tmo, input int rnd);
    logic [3:0] want;
    checks++;
    if (estado !== 4'd2 || jogadas !== tgt) begin
      failures++;
      $display("FAIL mostra_r%0d: estado=%0d jogadas=%b, want 2/%b", rnd, estado, jogadas, tgt);
    end
    step();
    checks++;
    if (estado !== 4'd3 || jogadas !== tgt) begin
      failures++;
      $display("FAIL espera_r%0d: estado=%0d jogadas=%b, want 3/%b", rnd, estado, jogadas, tgt);
    end
    if (press != 7'd0) begin
      botoes = press;
      step();
      botoes = '0;
      want = (press == tgt) ? 4'd4 : 4'd5;
      checks++;
      if (estado !== want || jogadas !== press) begin
        failures++;
        $display("FAIL result_r%0d: estado=%0d jogadas=%b, want %0d/%b",
                 rnd, estado, jogadas, want, press);
      end
    end else begin
      for (int i = 0; i < int'(tmo) - 1; i++) step();
      checks++;
      if (estado !== 4'd3) begin
        failures++;
        $display("FAIL pre_timeout_r%0d: estado=%0d, want 3", rnd, estado);
      end
      step();
      checks++;
      if (estado !== 4'd5 || jogadas !== 7'd0) begin
        failures++;
        $display("FAIL timeout_r%0d: estado=%0d jogadas=%b, want 5/0000000", rnd, estado, jogadas);
      end
    end
    step();
    checks++;
    if (estado !== 4'd6 || jogadas !== 7'd0) begin
      failures++;
      $display("FAIL proxima_r%0d: estado=%0d jogadas=%b, want 6/0000000", rnd, estado, jogadas);
    end
    step();
  endtask

  task automatic test_easy_perfect();
    logic [6:0] tg [4] = '{7'b0000001, 7'b0001000, 7'b0100000, 7'b0000010};
    start_game(1'b0, "easy");
    for (int r = 0; r < 4; r++) play_round(tg[r], tg[r], T_FACIL, r);
    checks++;
    if (estado !== 4'd7 || pronto !== 1'b1 || pontuacao !== 3'd4) begin
      failures++;
      $display("FAIL easy_fim: estado=%0d pronto=%b pontuacao=%0d, want 7/1/4",
               estado, pronto, pontuacao);
    end
    jogar = 1'b0;
    step(); step();
    checks++;
    if (estado !== 4'd7 || pontuacao !== 3'd4) begin
      failures++;
      $display("FAIL fim_hold: estado=%0d pontuacao=%0d, want 7/4", estado, pontuacao);
    end
  endtask

  task automatic test_hard_mixed();
    logic [6:0] tg [7] = '{7'b0000001, 7'b0001000, 7'b0100000, 7'b0000010,
                           7'b1000000, 7'b0000100, 7'b0010000};
    logic [6:0] pr [7] = '{7'b0000001, 7'b0000001, 7'b0100000, 7'b0000001,
                           7'b1000000, 7'b0000011, 7'b0000000};
    start_game(1'b1, "restart_hard");
    dificuldade = 1'b0;  // must not matter once latched
    for (int r = 0; r < 7; r++) begin
      play_round(tg[r], pr[r], T_DIFICIL, 10 + r);
      // jogar mid-game must be ignored
      jogar = (r == 2);
    end
    jogar = 1'b0;
    checks++;
    if (estado !== 4'd7 || pronto !== 1'b1 || pontuacao !== 3'd3) begin
      failures++;
      $display("FAIL hard_fim: estado=%0d pronto=%b pontuacao=%0d, want 7/1/3",
               estado, pronto, pontuacao);
    end
  endtask

  task automatic test_timeout();
    logic [6:0] tg [4] = '{7'b0000001, 7'b0001000, 7'b0100000, 7'b0000010};
    start_game(1'b0, "restart_easy");
    for (int r = 0; r < 4; r++) play_round(tg[r], 7'd0, T_FACIL, 20 + r);
    checks++;
    if (estado !== 4'd7 || pronto !== 1'b1 || pontuacao !== 3'd0) begin
      failures++;
      $display("FAIL timeout_fim: estado=%0d pronto=%b pontuacao=%0d, want 7/1/0",
               estado, pronto, pontuacao);
    end
  endtask

  task automatic test_held_button();
    botoes = 7'b0000001;
    start_game(1'b0, "held");
    step();
    step(); step();
    checks++;
    if (estado !== 4'd3) begin
      failures++;
      $display("FAIL held_no_event: estado=%0d, want 3", estado);
    end
    botoes = '0;
    step();
    checks++;
    if (estado !== 4'd3) begin
      failures++;
      $display("FAIL held_release: estado=%0d, want 3", estado);
    end
    botoes = 7'b0000001;
    step();
    botoes = '0;
    checks++;
    if (estado !== 4'd4 || jogadas !== 7'b0000001) begin
      failures++;
      $display("FAIL held_repress: estado=%0d jogadas=%b, want 4/0000001", estado, jogadas);
    end
    step(); step(); step();
    checks++;
    if (estado !== 4'd3 || pontuacao !== 3'd1 || jogadas !== 7'b0001000) begin
      failures++;
      $display("FAIL round1_espera: estado=%0d pontuacao=%0d jogadas=%b, want 3/1/0001000",
               estado, pontuacao, jogadas);
    end
  endtask

  task automatic test_reset_midgame();
    step();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (estado !== 4'd0 || jogadas !== 7'd0 || pontuacao !== 3'd0 || pronto !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: estado=%0d jogadas=%b pontuacao=%0d pronto=%b, want 0/0/0/0",
               estado, jogadas, pontuacao, pronto);
    end
    step();
    reset = 1'b1;
    step(); step();
    checks++;
    if (estado !== 4'd0) begin
      failures++;
      $display("FAIL post_reset_idle: estado=%0d, want 0", estado);
    end
  endtask

  initial begin
    test_reset();
    test_easy_perfect();
    test_hard_mixed();
    test_timeout();
    test_held_button();
    test_reset_midgame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cake_game.md
Name: cake_game

Overview:
- Cake-assembly minigame of the BitBakery console; the top level selects it when the minigame selector is 1.
- The player must press the button for each ingredient of a fixed recipe, one per round, before a per-round timeout expires.
- It reports its FSM state, the current target or captured press, the score, and a done flag.
- Its interface matches the other minigames so the top-level output mux treats all games identically.

Parameters:
- TEMPO_FACIL, 3000: timeout per round in easy mode, in clock cycles.
- TEMPO_DIFICIL, 1500: timeout per round in hard mode, in clock cycles.
- RODADAS_FACIL, 4: rounds per game in easy mode.
- RODADAS_DIFICIL, 7: rounds per game in hard mode.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- jogar  input  1  start request, sampled in INICIAL and FIM.
- dificuldade  input  1  0 = easy, 1 = hard; latched in PREPARA.
- botoes  input  7  ingredient buttons, active-high, already inverted by the top level.
- estado  output  4  current FSM state code.
- jogadas  output  7  one-hot target ingredient, or the captured button pattern.
- pontuacao  output  3  number of correct rounds.
- pronto  output  1  high while the game is finished.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state becomes INICIAL; score, round index, timer, latched difficulty and button history are cleared.
  - Outputs during reset: estado = 0, jogadas = 0, pontuacao = 0, pronto = 0.
- State codes: INICIAL = 0, PREPARA = 1, MOSTRA = 2, ESPERA = 3, ACERTO = 4, ERRO = 5, PROXIMA = 6, FIM = 7. Unused codes go to INICIAL.
- Recipe ROM: the target ingredient index for rounds 0..6 is 0, 3, 5, 1, 6, 2, 4. The target is the one-hot value 1 << index.
- Transitions:
  - INICIAL: go to PREPARA if jogar = 1, else stay.
  - PREPARA (1 cycle): score = 0, round = 0, timer = 0, latch dificuldade. Go to MOSTRA.
  - MOSTRA (1 cycle): load the target from the ROM and clear the timer. Go to ESPERA.
  - ESPERA: the timer increments each cycle.
    - A press event is a cycle where the registered previous botoes = 0 and the current botoes ≠ 0. On a press event, capture botoes.
    - If the captured value equals the target exactly, go to ACERTO; otherwise go to ERRO. A multi-button press is an error.
    - If the timer reaches the timeout − 1 with no press event, go to ERRO. A press event in that same cycle takes priority.
    - Buttons held down while entering ESPERA do not count; they must be released and pressed again.
  - ACERTO (1 cycle): score + 1, saturating at 7. Go to PROXIMA.
  - ERRO (1 cycle): score unchanged. Go to PROXIMA.
  - PROXIMA (1 cycle): if round = rounds − 1, go to FIM; else round + 1 and go to MOSTRA.
  - FIM: pronto = 1. Go to PREPARA if jogar = 1, else stay.
- Rounds and timeout are selected by the difficulty latched in PREPARA. Changing dificuldade mid-game has no effect.
- jogadas output:
  - target during MOSTRA and ESPERA;
  - captured press during ACERTO and ERRO;
  - 0 in all other states.
- pontuacao is registered and holds its value through FIM until the next PREPARA.
- pronto is registered; it is 1 only in FIM.
- jogar outside INICIAL and FIM is ignored.
- The button history register updates every cycle in every state.

Test Plan:
- Reset with reset = 0 mid-game in ESPERA -> estado = 0, pontuacao = 0, pronto = 0, jogadas = 0 immediately, without waiting for a clock edge.
- Easy game, perfect run:
  - Stimulus: jogar pulse; press 0000001, 0001000, 0100000, 0000010, each released between presses.
  - Response: estado passes 1, 2, 3, 4, 6 each round; pontuacao = 4; estado = 7 with pronto = 1.
- Hard game, wrong answers and multi-press:
  - Stimulus: jogar with dificuldade = 1; press the correct button in rounds 0, 2 and 4, a wrong single button in rounds 1 and 3, and 0000011 in round 5; time out in round 6.
  - Response: state 5 for rounds 1, 3, 5 and 6; pontuacao = 3 after 7 rounds.
- Timeout with TEMPO_FACIL = 10: no press -> ERRO entered exactly 10 cycles after entering ESPERA, jogadas = 0 there; game ends with pontuacao = 0.
- Held button: hold 0000001 from PREPARA through ESPERA -> no event; release then press -> ACERTO.
- Restart from FIM: jogar = 1 -> PREPARA, pontuacao cleared to 0, pronto = 0; the new difficulty is latched.
